neuron_layer_sequencer: RTL and testbench
=========================================

# neuron_layer_sequencer

Controller that time-multiplexes one shared floating-point multiply-accumulate unit and one sigmoid LUT unit across all neurons of a fully-connected layer. On `start` it walks neurons 0..N_NEURONS-1, fetching inputs, weights and bias from synchronous RAMs. It streams products through the MAC, applies ReLU internally or sigmoid via the LUT handshake, and writes each 32-bit IEEE-754 result to the output buffer. It sits between the layer memories and the neuron/activation datapath.

## Interface
- N_INPUTS, 3, inputs per neuron (≥1)
- N_NEURONS, 4, neurons in layer (≥1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins layer when idle
- act_sel  in  1  0 = ReLU, 1 = sigmoid; sampled on accepted `start`
- busy  out  1  high from accepted `start` until `done`
- done  out  1  one-cycle pulse after last write
- x_addr  out  $clog2(N_INPUTS)  input RAM address
- w_addr  out  $clog2(N_INPUTS*N_NEURONS)  weight RAM address = n*N_INPUTS+k
- b_addr  out  $clog2(N_NEURONS)  bias RAM address = n
- x_rdata, w_rdata, b_rdata  in  32  RAM data, valid the cycle after address
- mac_valid  out  1  operand beat valid
- mac_ready  in  1  MAC accepts beat when valid & ready
- mac_a, mac_b  out  32  input, weight
- mac_bias  out  32  bias, meaningful on first beat
- mac_first, mac_last  out  1  beat markers
- mac_res_valid  in  1  one-cycle pulse, sum available
- mac_result  in  32  bias + Σ a·b
- act_valid  out  1  sigmoid request
- act_ready  in  1  LUT accepts request
- act_in  out  32  sigmoid argument
- act_out_valid  in  1  one-cycle pulse, sigmoid result
- act_out  in  32  sigmoid result
- out_we  out  1  output buffer write strobe
- out_addr  out  $clog2(N_NEURONS)  = n
- out_data  out  32  activated neuron output

## Operation
- States: IDLE, FETCH, LOAD, ISSUE, WAIT_SUM, ACT_REQ, ACT_WAIT, WRITE, DONE.
- IDLE: `start` accepted → clear n, k; latch act_sel; busy=1; → FETCH.
- FETCH: drive x_addr=k, w_addr=n*N_INPUTS+k, b_addr=n; → LOAD.
- LOAD: register x_rdata, w_rdata, b_rdata into operand regs; → ISSUE.
- ISSUE: mac_valid=1; mac_first=(k==0); mac_last=(k==N_INPUTS-1); operands held stable until handshake. On valid&ready: if last → WAIT_SUM, else k++ → FETCH.
- WAIT_SUM: on mac_res_valid latch mac_result. ReLU: result = sign bit ? 32'h0 : mac_result (−0 → +0) → WRITE. Sigmoid → ACT_REQ.
- ACT_REQ: act_valid=1, act_in held; on act_ready → ACT_WAIT. ACT_WAIT: on act_out_valid latch act_out → WRITE.
- WRITE: out_we=1 for one cycle, out_addr=n. If n==N_NEURONS-1 → DONE, else n++, k=0 → FETCH.
- DONE: done=1 one cycle, busy=0 → IDLE.
- `start` while busy ignored; act_sel changes mid-layer ignored.
- N_INPUTS=1: mac_first and mac_last both high on the single beat.
- mac_res_valid / act_out_valid outside their wait states ignored.

## Timing
- Reset (async assert, sync deassert usage): state=IDLE, n=k=0; busy, done, mac_valid, mac_first, mac_last, act_valid, out_we = 0; all address and data outputs = 0.
- Reset mid-layer: immediate return to IDLE; no further out_we; partial layer abandoned.
- Per beat with mac_ready tied high: 3 cycles (FETCH, LOAD, ISSUE).
- MAC latency L_m (cycles from last beat to mac_res_valid) and LUT latency are external; controller waits indefinitely, no timeout.
- ReLU neuron: 3·N_INPUTS + L_m + 1 (WAIT_SUM exit) + 1 (WRITE) cycles.
- done asserts the cycle after the final out_we; busy falls with done.
- Backpressure: mac_ready / act_ready low holds all operand outputs constant.

## Test plan
- ReLU, N_INPUTS=3, N_NEURONS=1, x=w={32'h40066666}×3, bias=0, MAC model returns 32'h4153AE14 → single out_we, out_addr=0, out_data=32'h4153AE14, then done pulse.
- ReLU negative: MAC model returns 32'hC0066666 → out_data=32'h00000000; 32'h80000000 → 32'h00000000.
- Sigmoid: MAC returns 32'h3E800000 → act_in=32'h3E800000; LUT model answers 32'h3F0FF5AA after 5 cycles → out_data=32'h3F0FF5AA.
- N_NEURONS=4, random mac_ready stalls → 12 accepted beats, w_addr sequence 0..11, four writes at addr 0..3, operands stable during stall.
- `start` pulsed while busy → no restart, write count unchanged; reset low during neuron 2 → all outputs 0 at once, no out_we afterward; fresh `start` runs a full layer.
- N_INPUTS=1 → every beat has mac_first=mac_last=1.

Source files
------------

// File: rtl/neuron_layer_sequencer.sv
// Sequences one shared MAC and one sigmoid LUT across every neuron of a
// fully-connected layer, writing one activated 32-bit result per neuron.
module neuron_layer_sequencer #(
    parameter int unsigned N_INPUTS  = 3,
    parameter int unsigned N_NEURONS = 4,
    localparam int unsigned XW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int unsigned WW = (N_INPUTS * N_NEURONS > 1) ? $clog2(N_INPUTS * N_NEURONS) : 1,
    localparam int unsigned NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          act_sel,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] x_addr,
    output logic [WW-1:0] w_addr,
    output logic [NW-1:0] b_addr,
    input  logic [31:0]   x_rdata,
    input  logic [31:0]   w_rdata,
    input  logic [31:0]   b_rdata,
    output logic          mac_valid,
    input  logic          mac_ready,
    output logic [31:0]   mac_a,
    output logic [31:0]   mac_b,
    output logic [31:0]   mac_bias,
    output logic          mac_first,
    output logic          mac_last,
    input  logic          mac_res_valid,
    input  logic [31:0]   mac_result,
    output logic          act_valid,
    input  logic          act_ready,
    output logic [31:0]   act_in,
    input  logic          act_out_valid,
    input  logic [31:0]   act_out,
    output logic          out_we,
    output logic [NW-1:0] out_addr,
    output logic [31:0]   out_data
);

    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD, ISSUE, WAIT_SUM, ACT_REQ, ACT_WAIT, WRITE, DONE
    } state_t;

    localparam logic [XW-1:0] K_LAST = XW'(N_INPUTS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_NEURONS - 1);

    state_t        state;
    logic [XW-1:0] k;
    logic [NW-1:0] n;
    logic          use_sigmoid;

    // Addresses are registered on entry to FETCH so the RAMs see them for the
    // whole FETCH cycle; w_addr simply counts beats across the layer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            k           <= '0;
            n           <= '0;
            use_sigmoid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            x_addr      <= '0;
            w_addr      <= '0;
            b_addr      <= '0;
            mac_valid   <= 1'b0;
            mac_a       <= '0;
            mac_b       <= '0;
            mac_bias    <= '0;
            mac_first   <= 1'b0;
            mac_last    <= 1'b0;
            act_valid   <= 1'b0;
            act_in      <= '0;
            out_we      <= 1'b0;
            out_addr    <= '0;
            out_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n           <= '0;
                        k           <= '0;
                        use_sigmoid <= act_sel;
                        busy        <= 1'b1;
                        x_addr      <= '0;
                        w_addr      <= '0;
                        b_addr      <= '0;
                        state       <= FETCH;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    mac_a     <= x_rdata;
                    mac_b     <= w_rdata;
                    mac_bias  <= b_rdata;
                    mac_valid <= 1'b1;
                    mac_first <= (k == '0);
                    mac_last  <= (k == K_LAST);
                    state     <= ISSUE;
                end
                ISSUE: begin
                    if (mac_ready) begin
                        mac_valid <= 1'b0;
                        mac_first <= 1'b0;
                        mac_last  <= 1'b0;
                        if (k == K_LAST) begin
                            state <= WAIT_SUM;
                        end else begin
                            k      <= k + 1'b1;
                            x_addr <= k + 1'b1;
                            w_addr <= w_addr + 1'b1;
                            state  <= FETCH;
                        end
                    end
                end
                WAIT_SUM: begin
                    if (mac_res_valid) begin
                        if (use_sigmoid) begin
                            act_in    <= mac_result;
                            act_valid <= 1'b1;
                            state     <= ACT_REQ;
                        end else begin
                            // Any negative sum, including -0, clamps to +0.
                            out_data <= mac_result[31] ? 32'h0 : mac_result;
                            out_we   <= 1'b1;
                            out_addr <= n;
                            state    <= WRITE;
                        end
                    end
                end
                ACT_REQ: begin
                    if (act_ready) begin
                        act_valid <= 1'b0;
                        state     <= ACT_WAIT;
                    end
                end
                ACT_WAIT: begin
                    if (act_out_valid) begin
                        out_data <= act_out;
                        out_we   <= 1'b1;
                        out_addr <= n;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    out_we <= 1'b0;
                    if (n == N_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        n      <= n + 1'b1;
                        k      <= '0;
                        x_addr <= '0;
                        w_addr <= w_addr + 1'b1;
                        b_addr <= n + 1'b1;
                        state  <= FETCH;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Randomized bench for neuron_layer_sequencer: RAM, MAC and LUT models plus a
// per-neuron reference of expected beats and writes.
module tb_neuron_layer_sequencer;

    localparam int unsigned NI  = 3;
    localparam int unsigned NN  = 4;
    localparam int unsigned NN2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        start, act_sel, busy, done;
    logic [1:0]  x_addr, b_addr, out_addr;
    logic [3:0]  w_addr;
    logic [31:0] x_rdata, w_rdata, b_rdata;
    logic        mac_valid, mac_first, mac_last;
    logic        mac_ready = 1'b1, mac_res_valid = 1'b0;
    logic [31:0] mac_a, mac_b, mac_bias, mac_result = '0;
    logic        act_valid, act_ready = 1'b1, act_out_valid = 1'b0;
    logic [31:0] act_in, act_out = '0;
    logic        out_we;
    logic [31:0] out_data;

    logic        start2, busy2, done2;
    logic [0:0]  x_addr2, w_addr2, b_addr2, out_addr2;
    logic [31:0] x_rdata2, w_rdata2, b_rdata2;
    logic        mac_valid2, mac_first2, mac_last2, mac_res_valid2 = 1'b0;
    logic [31:0] mac_a2, mac_b2, mac_bias2, mac_result2 = '0;
    logic        act_valid2, out_we2;
    logic [31:0] act_in2, out_data2;

    neuron_layer_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN)) dut (
        .clk(clk), .reset(reset), .start(start), .act_sel(act_sel), .busy(busy), .done(done),
        .x_addr(x_addr), .w_addr(w_addr), .b_addr(b_addr),
        .x_rdata(x_rdata), .w_rdata(w_rdata), .b_rdata(b_rdata),
        .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_a(mac_a), .mac_b(mac_b),
        .mac_bias(mac_bias), .mac_first(mac_first), .mac_last(mac_last),
        .mac_res_valid(mac_res_valid), .mac_result(mac_result),
        .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in),
        .act_out_valid(act_out_valid), .act_out(act_out),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    neuron_layer_sequencer #(.N_INPUTS(1), .N_NEURONS(NN2)) dut_single (
        .clk(clk), .reset(reset), .start(start2), .act_sel(1'b0), .busy(busy2), .done(done2),
        .x_addr(x_addr2), .w_addr(w_addr2), .b_addr(b_addr2),
        .x_rdata(x_rdata2), .w_rdata(w_rdata2), .b_rdata(b_rdata2),
        .mac_valid(mac_valid2), .mac_ready(1'b1), .mac_a(mac_a2), .mac_b(mac_b2),
        .mac_bias(mac_bias2), .mac_first(mac_first2), .mac_last(mac_last2),
        .mac_res_valid(mac_res_valid2), .mac_result(mac_result2),
        .act_valid(act_valid2), .act_ready(1'b1), .act_in(act_in2),
        .act_out_valid(1'b0), .act_out(32'h0),
        .out_we(out_we2), .out_addr(out_addr2), .out_data(out_data2)
    );

    logic [31:0] x_mem [NI];
    logic [31:0] w_mem [NI*NN];
    logic [31:0] b_mem [NN];
    logic [31:0] mac_ret [NN];
    logic [31:0] lut_ret [NN];
    logic [31:0] x2_mem [2];
    logic [31:0] w2_mem [2];
    logic [31:0] b2_mem [2];
    logic [31:0] ret2 [NN2];

    always @(posedge clk) begin
        x_rdata  <= x_mem[x_addr];
        w_rdata  <= w_mem[w_addr];
        b_rdata  <= b_mem[b_addr];
        x_rdata2 <= x2_mem[x_addr2];
        w_rdata2 <= w2_mem[w_addr2];
        b_rdata2 <= b2_mem[b_addr2];
    end

    int checks = 0, failures = 0;
    int beat_n, beat_k, beats, writes, dones, mac_n, lut_n, mac_cnt, lut_cnt;
    int stall_pct = 0, act_stall_pct = 0, cyc_cnt = 0, we_cyc = 0;
    int n2, beats2, writes2, res2_n, mac2_cnt;
    logic sel_model;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] relu(input logic [31:0] v);
        return v[31] ? 32'h0 : v;
    endfunction

    function automatic logic [31:0] exp_out(input int i);
        return sel_model ? lut_ret[i] : relu(mac_ret[i]);
    endfunction

    // Response models: MAC sum and LUT result arrive some cycles after the
    // request; stray pulses are injected while no response is owed.
    always @(posedge clk) begin
        #1;
        cyc_cnt++;
        mac_res_valid  = 1'b0;
        act_out_valid  = 1'b0;
        mac_res_valid2 = 1'b0;
        if (mac_cnt > 0) begin
            mac_cnt--;
            if (mac_cnt == 0) begin
                mac_result    = (mac_n < NN) ? mac_ret[mac_n] : 32'hDEADBEEF;
                mac_n++;
                mac_res_valid = 1'b1;
            end
        end else if ($urandom_range(0, 9) == 0) begin
            mac_result    = 32'hDEADBEEF;
            mac_res_valid = 1'b1;
        end
        if (lut_cnt > 0) begin
            lut_cnt--;
            if (lut_cnt == 0) begin
                act_out       = (lut_n < NN) ? lut_ret[lut_n] : 32'hBADC0DE0;
                lut_n++;
                act_out_valid = 1'b1;
            end
        end else if ($urandom_range(0, 9) == 0) begin
            act_out       = 32'hBADC0DE0;
            act_out_valid = 1'b1;
        end
        if (mac2_cnt > 0) begin
            mac2_cnt--;
            if (mac2_cnt == 0) begin
                mac_result2    = (res2_n < NN2) ? ret2[res2_n] : 32'hDEADBEEF;
                res2_n++;
                mac_res_valid2 = 1'b1;
            end
        end
        mac_ready = ($urandom_range(0, 99) >= stall_pct);
        act_ready = ($urandom_range(0, 99) >= act_stall_pct);
    end

    always @(negedge clk) begin
        if (reset) begin
            if (mac_valid) begin
                check("mac_a", mac_a, x_mem[beat_k]);
                check("mac_b", mac_b, w_mem[beat_n*NI + beat_k]);
                check("mac_bias", mac_bias, b_mem[beat_n]);
                check("x_addr", x_addr, beat_k);
                check("w_addr", w_addr, beat_n*NI + beat_k);
                check("b_addr", b_addr, beat_n);
                check("mac_first", mac_first, beat_k == 0);
                check("mac_last", mac_last, beat_k == NI-1);
                if (mac_ready) begin
                    beats++;
                    if (beat_k == NI-1) begin
                        beat_k  = 0;
                        beat_n++;
                        mac_cnt = 1 + $urandom_range(0, 4);
                    end else begin
                        beat_k++;
                    end
                end
            end
            if (act_valid) begin
                check("act_in", act_in, mac_ret[writes]);
                if (act_ready) lut_cnt = 5;
            end
            if (out_we) begin
                check("out_addr", out_addr, writes);
                check("out_data", out_data, exp_out(writes));
                writes++;
                we_cyc = cyc_cnt;
            end
            if (done) begin
                dones++;
                check("done_writes", writes, NN);
                check("done_busy", busy, 0);
                check("done_latency", cyc_cnt, we_cyc + 1);
            end
            if (mac_valid2) begin
                check("single_first", mac_first2, 1);
                check("single_last", mac_last2, 1);
                check("single_a", mac_a2, x2_mem[0]);
                check("single_b", mac_b2, w2_mem[n2]);
                check("single_bias", mac_bias2, b2_mem[n2]);
                n2++;
                beats2++;
                mac2_cnt = 2;
            end
            if (out_we2) begin
                check("single_out_addr", out_addr2, writes2);
                check("single_out_data", out_data2, relu(ret2[writes2]));
                writes2++;
            end
        end
    end

    task automatic randomize_mems();
        foreach (x_mem[i]) x_mem[i] = $urandom;
        foreach (w_mem[i]) w_mem[i] = $urandom;
        foreach (b_mem[i]) b_mem[i] = $urandom;
        foreach (mac_ret[i]) mac_ret[i] = $urandom;
        foreach (lut_ret[i]) lut_ret[i] = $urandom;
    endtask

    task automatic begin_layer(input logic sel, input int stall);
        sel_model = sel;
        stall_pct = stall;
        act_stall_pct = stall;
        beat_n = 0; beat_k = 0; beats = 0; writes = 0; dones = 0;
        mac_n = 0; lut_n = 0; mac_cnt = 0; lut_cnt = 0;
        @(posedge clk); #2;
        start = 1'b1;
        act_sel = sel;
        @(posedge clk); #2;
        start = 1'b0;
        act_sel = ~sel;
        check("busy_after_start", busy, 1);
    endtask

    task automatic run_layer(input logic sel, input int stall, input bit poke);
        int cyc;
        begin_layer(sel, stall);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #2;
            cyc++;
            start = (poke && cyc == 20);
        end
        start = 1'b0;
        check("layer_timeout", cyc < 3000, 1);
        @(negedge clk); #1;
        check("beats", beats, NI*NN);
        check("writes", writes, NN);
        repeat (20) @(posedge clk);
        #2;
        check("idle_busy", busy, 0);
        check("dones", dones, 1);
        check("writes_after", writes, NN);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {busy, done, mac_valid, mac_first, mac_last, act_valid, out_we,
                              x_addr, w_addr, b_addr, out_addr}, 0);
        check({tag, "_mac"}, {mac_a, mac_b}, 0);
        check({tag, "_bias_act"}, {mac_bias, act_in}, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int cyc;
        reset = 1'b0; start = 1'b0; act_sel = 1'b0; start2 = 1'b0;
        n2 = 0; beats2 = 0; writes2 = 0; res2_n = 0; mac2_cnt = 0;
        mac_cnt = 0; lut_cnt = 0; writes = 0;
        randomize_mems();
        foreach (x2_mem[i]) x2_mem[i] = $urandom;
        foreach (w2_mem[i]) w2_mem[i] = $urandom;
        foreach (b2_mem[i]) b2_mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk) reset = 1'b1;

        // ReLU with known sums: positive, negative, -0, positive.
        foreach (x_mem[i]) x_mem[i] = 32'h40066666;
        foreach (w_mem[i]) w_mem[i] = 32'h40066666;
        foreach (b_mem[i]) b_mem[i] = 32'h0;
        mac_ret[0] = 32'h4153AE14; mac_ret[1] = 32'hC0066666;
        mac_ret[2] = 32'h80000000; mac_ret[3] = 32'h3F800000;
        run_layer(1'b0, 0, 1'b0);

        // Sigmoid with backpressure, a start pulse mid-layer and act_sel toggled.
        randomize_mems();
        mac_ret[0] = 32'h3E800000;
        lut_ret[0] = 32'h3F0FF5AA;
        run_layer(1'b1, 40, 1'b1);

        randomize_mems();
        run_layer(1'b0, 50, 1'b1);

        // Reset in the middle of neuron 2.
        randomize_mems();
        begin_layer(1'b0, 30);
        cyc = 0;
        while (writes < 2 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        check("abort_reach", writes, 2);
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (30) @(posedge clk);
        #2;
        check("abort_no_write", writes, 2);
        check("abort_idle", busy, 0);

        randomize_mems();
        run_layer(1'b1, 25, 1'b0);

        // Single-input instance: every beat is both first and last.
        ret2[0] = $urandom | 32'h80000000;
        ret2[1] = $urandom & 32'h7FFFFFFF;
        @(posedge clk); #2;
        start2 = 1'b1;
        @(posedge clk); #2;
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 500) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("single_timeout", cyc < 500, 1);
        @(negedge clk); #1;
        check("single_beats", beats2, NN2);
        check("single_writes", writes2, NN2);
        check("single_busy", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
